rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 82 ++++++++
 tb/tb_rr_arbiter_4.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-channel round-robin arbiter with registered one-hot and binary grant outputs.
// The priority pointer advances past the served channel on each ack.
module rr_arbiter_4 #(
  parameter bit LOCK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       ack,
  output logic       gnt_valid,
  output logic [1:0] sel,
  output logic [3:0] gnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0] state, state_n;
  logic [1:0] ptr, ptr_n, sel_n;
  logic [3:0] gnt_n;
  logic [1:0] base;
  logic [1:0] win;
  logic       found;

  // An ack re-arbitrates in the same edge from the slot after the served channel.
  assign base = (state == ST_GRANT && ack) ? sel + 2'd1 : ptr;

  always_comb begin
    logic [1:0] idx;
    found = 1'b0;
    win   = base;
    idx   = base;
    // Scan from the farthest slot down so the nearest requester is kept last.
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    if (state == ST_IDLE) begin
      if (found) begin
        state_n = ST_GRANT;
        sel_n   = win;
      end
    end else begin
      if (ack) begin
        ptr_n = base;
        if (found) sel_n   = win;
        else       state_n = ST_IDLE;
      end else if (!LOCK && !req[sel]) begin
        state_n = ST_IDLE;
      end
    end
    gnt_n = (state_n == ST_GRANT) ? (4'b0001 << sel_n) : 4'b0000;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sel   <= 2'b00;
      ptr   <= 2'b00;
      gnt   <= 4'b0000;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
    end
  end

  assign gnt_valid = state[0];

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4: constant vector table, directed corner sequences,
// and random traffic against a distance-based round-robin model, for both LOCK settings.
module tb_rr_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       ack = 1'b0;

  logic       v0, v1;
  logic [1:0] s0, s1;
  logic [3:0] g0, g1;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, index 0 = LOCK=0 instance, index 1 = LOCK=1 instance.
  int m_v[2];
  int m_sel[2];
  int m_ptr[2];

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic       v;
    logic [1:0] sel;
    logic [3:0] gnt;
  } vec_t;

  vec_t tbl[20];

  rr_arbiter_4 #(.LOCK(1'b0)) u_lock0 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt_valid(v0), .sel(s0), .gnt(g0)
  );

  rr_arbiter_4 #(.LOCK(1'b1)) u_lock1 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .gnt_valid(v1), .sel(s1), .gnt(g1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int lock, input int v, input int s, input int g);
    if (lock == 1) begin
      check({name, "_valid"}, int'(v1), v);
      check({name, "_sel"},   int'(s1), s);
      check({name, "_gnt"},   int'(g1), g);
    end else begin
      check({name, "_valid"}, int'(v0), v);
      check({name, "_sel"},   int'(s0), s);
      check({name, "_gnt"},   int'(g0), g);
    end
  endtask

  function automatic int pick(input int p, input logic [3:0] r);
    int best = -1;
    int bd = 4;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        int d = (i - p + 4) % 4;
        if (d < bd) begin
          bd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_v[k] = 0; m_sel[k] = 0; m_ptr[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r, input logic a);
    int w;
    if (m_v[k] == 0) begin
      w = pick(m_ptr[k], r);
      if (w >= 0) begin
        m_v[k] = 1; m_sel[k] = w;
      end
    end else if (a) begin
      m_ptr[k] = (m_sel[k] + 1) % 4;
      w = pick(m_ptr[k], r);
      if (w >= 0) m_sel[k] = w;
      else        m_v[k] = 0;
    end else if (k == 0 && !r[m_sel[k]]) begin
      m_v[k] = 0;
    end
  endtask

  task automatic tick();
    logic [3:0] r;
    logic a;
    r = req;
    a = ack;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, r, a);
  endtask

  task automatic check_model(input string name);
    for (int k = 0; k < 2; k++)
      check_out($sformatf("%s_l%0d", name, k), k, m_v[k], m_sel[k],
                m_v[k] != 0 ? (1 << m_sel[k]) : 0);
    check({name, "_onehot0"}, int'($onehot0(g0) && $onehot0(g1)), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b0000;
    ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[1]  = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2};
    tbl[2]  = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4};
    tbl[3]  = '{4'hF, 1'b1, 1'b1, 2'd3, 4'h8};
    tbl[4]  = '{4'hF, 1'b1, 1'b1, 2'd0, 4'h1};
    tbl[5]  = '{4'hF, 1'b1, 1'b1, 2'd1, 4'h2};
    for (int i = 6; i < 11; i++) tbl[i] = '{4'hF, 1'b0, 1'b1, 2'd1, 4'h2};
    tbl[11] = '{4'hF, 1'b1, 1'b1, 2'd2, 4'h4};
    tbl[12] = '{4'h0, 1'b1, 1'b0, 2'd2, 4'h0};
    tbl[13] = '{4'h5, 1'b0, 1'b1, 2'd0, 4'h1};
    tbl[14] = '{4'h0, 1'b0, 1'b1, 2'd0, 4'h1};
    tbl[15] = '{4'h0, 1'b1, 1'b0, 2'd0, 4'h0};
    tbl[16] = '{4'h0, 1'b1, 1'b0, 2'd0, 4'h0};
    tbl[17] = '{4'h1, 1'b0, 1'b1, 2'd0, 4'h1};
    tbl[18] = '{4'hA, 1'b0, 1'b1, 2'd0, 4'h1};
    tbl[19] = '{4'hA, 1'b1, 1'b1, 2'd1, 4'h2};

    // Reset state, held low across edges.
    rst_n = 1'b0;
    #12;
    check_out("reset_l1", 1, 0, 0, 0);
    check_out("reset_l0", 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      req = tbl[i].req;
      ack = tbl[i].ack;
      tick();
      check_out($sformatf("vec%0d", i), 1, int'(tbl[i].v), int'(tbl[i].sel), int'(tbl[i].gnt));
    end

    // Single-cycle request on ch2 is locked until ack.
    do_reset();
    req = 4'b0100;
    tick();
    check_out("pulse_grant", 1, 1, 2, 4);
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("pulse_hold%0d", i), 1, 1, 2, 4);
    end
    ack = 1'b1;
    tick();
    check_out("pulse_release", 1, 0, 2, 0);
    ack = 1'b0;

    // LOCK=0 withdraws on request drop; pointer is not advanced.
    do_reset();
    req = 4'b1000;
    tick();
    check_out("drop_grant", 0, 1, 3, 8);
    req = 4'b0000;
    tick();
    check_out("drop_idle", 0, 0, 3, 0);
    check_out("drop_locked", 1, 1, 3, 8);
    req = 4'b1001;
    tick();
    check_out("drop_rearb", 0, 1, 0, 1);
    check_out("drop_locked2", 1, 1, 3, 8);

    // Asynchronous reset mid-grant, then restart from ptr=0.
    do_reset();
    req = 4'b0100;
    tick();
    check_out("areset_pre", 1, 1, 2, 4);
    #1 rst_n = 1'b0;
    #1;
    check_out("areset_l1", 1, 0, 0, 0);
    check_out("areset_l0", 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    model_reset();
    req = 4'b0100;
    tick();
    check_out("areset_post", 1, 1, 2, 4);
    req = 4'b1111;
    ack = 1'b1;
    tick();
    check_out("areset_next", 1, 1, 3, 8);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model($sformatf("rnd_rst%0d", c));
        #1 rst_n = 1'b1;
      end
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
